// File: rtl/can_frame_scheduler.sv
// Periodic multi-channel CAN transmit scheduler: round-robin arbitration, AXI4-Stream send, retry.
// Define CAN_SCHED_STATS_EN to build per-channel saturating ok/fail/overrun counters.
module can_frame_scheduler #(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned TICK_CYCLES = 50_000,
   parameter int unsigned PERIOD_W    = 8,
   parameter int unsigned MAX_RETRY   = 3,
   parameter logic [NUM_CH*11-1:0] CH_IDS = {11'h3F9, 11'h3E9, 11'h3D9, 11'h3C9}
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_CH-1:0]          ch_enable,
   input  logic [NUM_CH*PERIOD_W-1:0] ch_period,
   input  logic [NUM_CH*64-1:0]       ch_data,
   input  logic [NUM_CH*8-1:0]        ch_keep,
   output logic [63:0]                stm_send_data_out_tdata,
   output logic [10:0]                stm_send_data_out_tid,
   output logic [7:0]                 stm_send_data_out_tkeep,
   output logic                       stm_send_data_out_tvalid,
   input  logic                       stm_send_data_out_tready,
   input  logic [2:0]                 stm_result_in_tdata,
   input  logic                       stm_result_in_tvalid,
   output logic                       stm_result_in_tready,
   output logic [NUM_CH-1:0]          ch_fail,
   output logic                       busy,
   output logic [NUM_CH*16-1:0]       stat_ok_cnt,
   output logic [NUM_CH*16-1:0]       stat_fail_cnt,
   output logic [NUM_CH*16-1:0]       stat_ovr_cnt
);

   localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned PRE_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StSend   = 2'd1;
   localparam logic [1:0] StResult = 2'd2;

   logic [1:0]                     state_q, state_d;
   logic [PRE_W-1:0]               pre_q;
   logic                           tick;
   logic [NUM_CH-1:0][PERIOD_W-1:0] per_q, per_d;
   logic [NUM_CH-1:0]              pending_q, pending_d, set, active, clr;
   logic [IDX_W-1:0]               rr_q, idx_q, gnt_idx;
   logic                           gnt_vld, grant;
   logic [RTY_W-1:0]               rty_q;
   logic                           rty_inc, fail_evt;
   logic [10:0]                    id_q;
   logic [63:0]                    data_q;
   logic [7:0]                     keep_q;
   logic [NUM_CH-1:0]              fail_q;

   assign tick = (pre_q == PRE_W'(TICK_CYCLES - 1));

   // Wrap on >= so a period shortened below the running count recovers immediately.
   always_comb begin
      logic [PERIOD_W-1:0] prd;
      per_d  = per_q;
      set    = '0;
      active = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         prd = ch_period[i*PERIOD_W +: PERIOD_W];
         if (!ch_enable[i] || prd == '0) begin
            per_d[i] = '0;
         end else begin
            active[i] = 1'b1;
            if (tick) begin
               if (per_q[i] >= prd - 1'b1) begin
                  per_d[i] = '0;
                  set[i]   = 1'b1;
               end else begin
                  per_d[i] = per_q[i] + 1'b1;
               end
            end
         end
      end
   end

   // Walk downward so the lowest offset from rr+1 overwrites and wins.
   always_comb begin
      int unsigned idx;
      gnt_vld = 1'b0;
      gnt_idx = rr_q;
      for (int unsigned k = NUM_CH; k >= 1; k--) begin
         idx = (32'(rr_q) + k) % NUM_CH;
         if (pending_q[idx]) begin
            gnt_vld = 1'b1;
            gnt_idx = IDX_W'(idx);
         end
      end
   end

   assign grant = (state_q == StIdle) && gnt_vld;

   always_comb begin
      clr = '0;
      if (grant) clr[gnt_idx] = 1'b1;
      pending_d = ((pending_q & ~clr) | set) & active;
   end

   always_comb begin
      state_d  = state_q;
      rty_inc  = 1'b0;
      fail_evt = 1'b0;
      case (state_q)
         StIdle:   if (gnt_vld) state_d = StSend;
         StSend:   if (stm_send_data_out_tready) state_d = StResult;
         StResult: begin
            if (stm_result_in_tvalid) begin
               if (stm_result_in_tdata == 3'b000) begin
                  state_d = StIdle;
               end else if (rty_q < RTY_W'(MAX_RETRY)) begin
                  rty_inc = 1'b1;
                  state_d = StSend;
               end else begin
                  fail_evt = 1'b1;
                  state_d  = StIdle;
               end
            end
         end
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         pre_q     <= '0;
         per_q     <= '0;
         pending_q <= '0;
         rr_q      <= IDX_W'(NUM_CH - 1);
         idx_q     <= '0;
         rty_q     <= '0;
         id_q      <= '0;
         data_q    <= '0;
         keep_q    <= '0;
         fail_q    <= '0;
      end else begin
         state_q   <= state_d;
         pre_q     <= tick ? '0 : pre_q + 1'b1;
         per_q     <= per_d;
         pending_q <= pending_d;
         fail_q    <= '0;
         if (fail_evt) fail_q[idx_q] <= 1'b1;
         if (grant) begin
            id_q   <= CH_IDS[gnt_idx*11 +: 11];
            data_q <= ch_data[gnt_idx*64 +: 64];
            keep_q <= ch_keep[gnt_idx*8 +: 8];
            idx_q  <= gnt_idx;
            rr_q   <= gnt_idx;
            rty_q  <= '0;
         end else if (rty_inc) begin
            rty_q  <= rty_q + 1'b1;
         end
      end
   end

   assign stm_send_data_out_tvalid = (state_q == StSend);
   assign stm_send_data_out_tdata  = (state_q == StSend) ? data_q : '0;
   assign stm_send_data_out_tid    = (state_q == StSend) ? id_q : '0;
   assign stm_send_data_out_tkeep  = (state_q == StSend) ? keep_q : '0;
   assign stm_result_in_tready     = (state_q == StResult);
   assign busy                     = (state_q == StSend) || (state_q == StResult);
   assign ch_fail                  = fail_q;

`ifdef CAN_SCHED_STATS_EN
   logic [NUM_CH-1:0][15:0] ok_q, fcnt_q, ovr_q;
   logic                    ok_evt;
   logic [NUM_CH-1:0]       ovr;

   assign ok_evt = (state_q == StResult) && stm_result_in_tvalid && (stm_result_in_tdata == 3'b000);
   // A set landing on a still-pending channel that is not being granted this cycle is an overrun.
   assign ovr    = set & pending_q & ~clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ok_q   <= '0;
         fcnt_q <= '0;
         ovr_q  <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (ok_evt && idx_q == IDX_W'(i) && ok_q[i] != 16'hFFFF) ok_q[i] <= ok_q[i] + 1'b1;
            if (fail_evt && idx_q == IDX_W'(i) && fcnt_q[i] != 16'hFFFF)
               fcnt_q[i] <= fcnt_q[i] + 1'b1;
            if (ovr[i] && ovr_q[i] != 16'hFFFF) ovr_q[i] <= ovr_q[i] + 1'b1;
         end
      end
   end

   assign stat_ok_cnt   = ok_q;
   assign stat_fail_cnt = fcnt_q;
   assign stat_ovr_cnt  = ovr_q;
`else
   assign stat_ok_cnt   = '0;
   assign stat_fail_cnt = '0;
   assign stat_ovr_cnt  = '0;
`endif

endmodule

// File: tb/tb_can_frame_scheduler.sv
// Directed self-checking bench for can_frame_scheduler with a 10-cycle tick.
module tb_can_frame_scheduler;

   localparam int unsigned NUM_CH = 4;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [3:0]         ch_enable = '0;
   logic [31:0]        ch_period = '0;
   logic [255:0]       ch_data;
   logic [31:0]        ch_keep;
   logic [63:0]        tdata;
   logic [10:0]        tid;
   logic [7:0]         tkeep;
   logic               tvalid;
   logic               tready = 1'b0;
   logic [2:0]         res_data = '0;
   logic               res_valid = 1'b0;
   logic               res_ready;
   logic [3:0]         ch_fail;
   logic               busy;
   logic [63:0]        stat_ok, stat_fail, stat_ovr;

   int n_checks = 0;
   int n_fail = 0;

   logic [10:0] exp_id   [4] = '{11'h3C9, 11'h3D9, 11'h3E9, 11'h3F9};
   logic [63:0] exp_data [4] = '{64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444,
                                 64'h2222_3333_4444_5555, 64'h3333_4444_5555_6666};
   logic [7:0]  exp_keep [4] = '{8'hFF, 8'h3F, 8'h0F, 8'hF0};

   always #5 clk = ~clk;

   can_frame_scheduler #(
      .NUM_CH      (NUM_CH),
      .TICK_CYCLES (10),
      .PERIOD_W    (8),
      .MAX_RETRY   (3)
   ) dut (
      .clk                      (clk),
      .rst_n                    (rst_n),
      .ch_enable                (ch_enable),
      .ch_period                (ch_period),
      .ch_data                  (ch_data),
      .ch_keep                  (ch_keep),
      .stm_send_data_out_tdata  (tdata),
      .stm_send_data_out_tid    (tid),
      .stm_send_data_out_tkeep  (tkeep),
      .stm_send_data_out_tvalid (tvalid),
      .stm_send_data_out_tready (tready),
      .stm_result_in_tdata      (res_data),
      .stm_result_in_tvalid     (res_valid),
      .stm_result_in_tready     (res_ready),
      .ch_fail                  (ch_fail),
      .busy                     (busy),
      .stat_ok_cnt              (stat_ok),
      .stat_fail_cnt            (stat_fail),
      .stat_ovr_cnt             (stat_ovr)
   );

   task automatic restore_data();
      for (int i = 0; i < 4; i++) begin
         ch_data[i*64 +: 64] = exp_data[i];
         ch_keep[i*8 +: 8]   = exp_keep[i];
      end
   endtask

   // Returns at the negedge where rst_n is released; the k-th following negedge trails edge k.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      restore_data();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      int first;
      ch_enable = 4'b1111;
      ch_period = {8'd1, 8'd1, 8'd1, 8'd1};
      tready    = 1'b1;
      restore_data();
      #12;
      n_checks++;
      if ({tvalid, tdata, tid, tkeep, res_ready, busy, ch_fail} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: tvalid=%0b tid=%h busy=%0b ready=%0b, required all 0",
                  tvalid, tid, busy, res_ready);
      end
      ch_enable = 4'b0001;
      res_valid = 1'b1;
      res_data  = 3'b000;
      @(negedge clk);
      rst_n = 1'b1;
      first = -1;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         if (tvalid && first < 0) begin
            first = k;
            n_checks++;
            if (tid !== 11'h3C9) begin
               n_fail++;
               $display("FAIL reset_first_tid: got %h, required 3c9", tid);
            end
         end
      end
      n_checks++;
      if (first != 11) begin
         n_fail++;
         $display("FAIL reset_first_frame_cycle: got %0d, required 11", first);
      end
   endtask

   task automatic test_periodic();
      int first, second;
      ch_enable = 4'b0001;
      ch_period = {8'd0, 8'd0, 8'd0, 8'd2};
      tready    = 1'b1;
      res_valid = 1'b1;
      res_data  = 3'b000;
      do_reset();
      first  = -1;
      second = -1;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         if (tvalid) begin
            if (first < 0) begin
               first = c;
               n_checks++;
               if (tid !== 11'h3C9 || tdata !== exp_data[0] || tkeep !== 8'hFF) begin
                  n_fail++;
                  $display("FAIL periodic_frame1: tid=%h data=%h keep=%h, required 3c9 %h ff",
                           tid, tdata, tkeep, exp_data[0]);
               end
               ch_data[63:0] = 64'hCAFE_F00D_1234_5678;
            end else if (second < 0) begin
               second = c;
               n_checks++;
               if (tid !== 11'h3C9 || tdata !== 64'hCAFE_F00D_1234_5678) begin
                  n_fail++;
                  $display("FAIL periodic_frame2: tid=%h data=%h, required 3c9 cafef00d12345678",
                           tid, tdata);
               end
            end
         end
      end
      n_checks++;
      if (first != 21 || second != 41) begin
         n_fail++;
         $display("FAIL periodic_timing: frames at %0d,%0d, required 21,41", first, second);
      end
   endtask

   task automatic test_round_robin();
      logic [10:0] seq_id   [8];
      logic [63:0] seq_data [8];
      int nf;
      ch_enable = 4'b1111;
      ch_period = {8'd1, 8'd1, 8'd1, 8'd1};
      tready    = 1'b1;
      res_valid = 1'b1;
      res_data  = 3'b000;
      do_reset();
      nf = 0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (tvalid && nf < 8) begin
            seq_id[nf]   = tid;
            seq_data[nf] = tdata;
            nf++;
         end
      end
      n_checks++;
      if (nf != 8) begin
         n_fail++;
         $display("FAIL rr_frame_count: got %0d, required 8", nf);
      end
      for (int j = 0; j < nf; j++) begin
         n_checks++;
         if (seq_id[j] !== exp_id[j % 4] || seq_data[j] !== exp_data[j % 4]) begin
            n_fail++;
            $display("FAIL rr_order[%0d]: tid=%h data=%h, required %h %h", j, seq_id[j],
                     seq_data[j], exp_id[j % 4], exp_data[j % 4]);
         end
      end
   endtask

   task automatic test_retry();
      int sends, fails;
      ch_enable = 4'b0010;
      ch_period = {8'd0, 8'd0, 8'd1, 8'd0};
      tready    = 1'b1;
      res_valid = 1'b1;
      res_data  = 3'b010;
      do_reset();
      sends = 0;
      fails = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (ch_fail != 4'b0000) fails++;
         if (tvalid) begin
            sends++;
            n_checks++;
            if (tid !== 11'h3D9 || tdata !== exp_data[1] || tkeep !== 8'h3F) begin
               n_fail++;
               $display("FAIL retry_send%0d: tid=%h data=%h, required 3d9 %h", sends, tid,
                        tdata, exp_data[1]);
            end
            if (sends == 1) ch_enable = 4'b0000;
            res_data = (sends < 4) ? 3'b010 : 3'b000;
         end
      end
      n_checks++;
      if (sends != 4 || fails != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL retry_summary: sends=%0d fail_cycles=%0d busy=%0b, required 4 0 0",
                  sends, fails, busy);
      end
      n_checks++;
`ifdef CAN_SCHED_STATS_EN
      if (stat_ok[16 +: 16] !== 16'd1 || stat_fail !== '0) begin
         n_fail++;
         $display("FAIL retry_stat_ok: ok1=%0d fail=%h, required 1 0", stat_ok[16 +: 16],
                  stat_fail);
      end
`else
      if (stat_ok !== '0 || stat_fail !== '0 || stat_ovr !== '0) begin
         n_fail++;
         $display("FAIL stats_tied_off: ok=%h fail=%h ovr=%h, required 0", stat_ok,
                  stat_fail, stat_ovr);
      end
`endif
   endtask

   task automatic test_fail();
      int sends, pulses, bad;
      ch_enable = 4'b0100;
      ch_period = {8'd0, 8'd1, 8'd0, 8'd0};
      tready    = 1'b1;
      res_valid = 1'b1;
      res_data  = 3'b001;
      do_reset();
      sends  = 0;
      pulses = 0;
      bad    = 0;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (ch_fail == 4'b0100) pulses++;
         else if (ch_fail != 4'b0000) bad++;
         if (tvalid) begin
            sends++;
            n_checks++;
            if (tid !== 11'h3E9 || tdata !== exp_data[2]) begin
               n_fail++;
               $display("FAIL fail_send%0d: tid=%h data=%h, required 3e9 %h", sends, tid,
                        tdata, exp_data[2]);
            end
            if (sends == 1) ch_enable = 4'b0000;
         end
      end
      n_checks++;
      if (sends != 4 || pulses != 1 || bad != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL fail_summary: sends=%0d pulse=%0d stray=%0d busy=%0b, required 4 1 0 0",
                  sends, pulses, bad, busy);
      end
`ifdef CAN_SCHED_STATS_EN
      n_checks++;
      if (stat_fail[32 +: 16] !== 16'd1 || stat_ok !== '0) begin
         n_fail++;
         $display("FAIL fail_stat: fail2=%0d ok=%h, required 1 0", stat_fail[32 +: 16],
                  stat_ok);
      end
`endif
   endtask

   task automatic test_stall();
      int first, unstable, hs;
      ch_enable = 4'b0001;
      ch_period = {8'd0, 8'd0, 8'd0, 8'd1};
      tready    = 1'b0;
      res_valid = 1'b1;
      res_data  = 3'b000;
      do_reset();
      first = -1;
      for (int c = 1; c <= 30 && first < 0; c++) begin
         @(negedge clk);
         if (tvalid) first = c;
      end
      n_checks++;
      if (first != 11) begin
         n_fail++;
         $display("FAIL stall_first_frame: got %0d, required 11", first);
      end
      ch_data[63:0] = 64'hDEAD_BEEF_0000_0001;
      unstable = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (!tvalid || tid !== 11'h3C9 || tdata !== exp_data[0] || tkeep !== 8'hFF) unstable++;
      end
      n_checks++;
      if (unstable != 0) begin
         n_fail++;
         $display("FAIL stall_stable: %0d unstable cycles, required 0", unstable);
      end
`ifdef CAN_SCHED_STATS_EN
      n_checks++;
      if (stat_ovr[15:0] !== 16'd4) begin
         n_fail++;
         $display("FAIL stall_ovr: got %0d, required 4", stat_ovr[15:0]);
      end
`endif
      tready = 1'b1;
      hs = 0;
      for (int j = 0; j < 8; j++) begin
         if (j > 0) @(negedge clk);
         if (tvalid && tready) begin
            hs++;
            if (hs == 2) begin
               n_checks++;
               if (tdata !== 64'hDEAD_BEEF_0000_0001) begin
                  n_fail++;
                  $display("FAIL stall_second_data: got %h, required deadbeef00000001", tdata);
               end
            end
         end
      end
      n_checks++;
      if (hs != 2) begin
         n_fail++;
         $display("FAIL stall_single_pending: %0d frames after release, required 2", hs);
      end
   endtask

   task automatic test_reset_mid();
      int waited, first;
      ch_enable = 4'b0001;
      ch_period = {8'd0, 8'd0, 8'd0, 8'd1};
      tready    = 1'b1;
      res_valid = 1'b0;
      do_reset();
      waited = 0;
      while (!res_ready && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      n_checks++;
      if (waited != 12) begin
         n_fail++;
         $display("FAIL midreset_result_state: reached after %0d, required 12", waited);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({tvalid, tdata, tid, tkeep, res_ready, busy, ch_fail} !== '0) begin
         n_fail++;
         $display("FAIL midreset_outputs: tvalid=%0b ready=%0b busy=%0b, required 0 0 0",
                  tvalid, res_ready, busy);
      end
      res_valid = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      first = -1;
      for (int k = 1; k <= 30 && first < 0; k++) begin
         @(negedge clk);
         if (tvalid) first = k;
      end
      n_checks++;
      if (first != 11 || tid !== 11'h3C9) begin
         n_fail++;
         $display("FAIL midreset_restart: frame at %0d tid=%h, required 11 3c9", first, tid);
      end
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_round_robin();
      test_retry();
      test_fail();
      test_stall();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
